// File: rtl/param_seq_detector_pkg.sv
// seq_det_pkg: constants and helpers shared by the serial sequence detector.
//   SEQ_DET_MAX_LEN         - largest supported pattern length
//   SEQ_DET_DEFAULT_PATTERN - pattern loaded at reset (LSB-aligned, first bit is MSB)
//   sat_inc()               - saturating increment against an explicit ceiling
package seq_det_pkg;

  localparam int unsigned SEQ_DET_MAX_LEN = 16;
  localparam logic [SEQ_DET_MAX_LEN-1:0] SEQ_DET_DEFAULT_PATTERN = 16'b1010;

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] ceiling);
    return (value >= ceiling) ? ceiling : value + 32'd1;
  endfunction

endpackage

// File: rtl/param_seq_detector.sv
// param_seq_detector: parametrised Mealy serial-bit sequence detector.
//   Pattern length LEN (2..16), pattern runtime-loadable via cfg_load,
//   overlapping or non-overlapping detection selected per bit by overlap.
//   Optional saturating match counter enabled by SEQ_DET_MATCH_CNT_EN.
// Ports:
//   clk         - rising-edge clock
//   rst_n       - synchronous active-low reset
//   x, x_valid  - serial data bit and its qualifier
//   overlap     - 1 = overlapping, 0 = non-overlapping detection
//   cfg_load    - load cfg_pattern (clears history, discards x this cycle)
//   cfg_pattern - new pattern, bit LEN-1 is the first bit received
//   z           - single-cycle Mealy match pulse
//   match_cnt   - saturating match count (tied to 0 unless SEQ_DET_MATCH_CNT_EN)
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned    LEN             = 4,
  parameter logic [LEN-1:0] DEFAULT_PATTERN = LEN'(SEQ_DET_DEFAULT_PATTERN),
  parameter int unsigned    CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             cfg_load,
  input  logic [LEN-1:0]   cfg_pattern,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FILL_W = $clog2(LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN - 1);

  logic [LEN-1:0]    pat_q;
  logic [LEN-2:0]    hist_q;
  logic [FILL_W-1:0] fill_q;
  logic [LEN-1:0]    win;
  logic              full;

  assign win  = {hist_q, x};
  assign full = (fill_q == FILL_FULL);
  // cfg_load masks the match so the discarded bit can never pulse z.
  assign z    = x_valid & ~cfg_load & full & (win == pat_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q  <= DEFAULT_PATTERN;
      hist_q <= '0;
      fill_q <= '0;
    end else if (cfg_load) begin
      pat_q  <= cfg_pattern;
      hist_q <= '0;
      fill_q <= '0;
    end else if (x_valid) begin
      if (z && !overlap) begin
        // Non-overlapping: the next match needs LEN fresh bits.
        hist_q <= '0;
        fill_q <= '0;
      end else begin
        hist_q <= win[LEN-2:0];
        if (!full) fill_q <= fill_q + 1'b1;
      end
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || cfg_load) begin
      cnt_q <= '0;
    end else if (z) begin
      cnt_q <= CNT_W'(sat_inc(32'(cnt_q), 32'({CNT_W{1'b1}})));
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector: bench for param_seq_detector (LEN=4, CNT_W=2).
// A queue-based model of accepted bits predicts z and match_cnt every cycle;
// directed scenarios also pin hand-computed z sequences and counts.
// Counter expectations follow SEQ_DET_MATCH_CNT_EN (0 when undefined).
module tb_param_seq_detector;

  localparam int unsigned LEN   = 4;
  localparam int unsigned CNT_W = 2;
`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             x = 1'b0;
  logic             x_valid = 1'b0;
  logic             overlap = 1'b1;
  logic             cfg_load = 1'b0;
  logic [LEN-1:0]   cfg_pattern = '0;
  logic             z;
  logic [CNT_W-1:0] match_cnt;

  int vectors = 0;
  int miscompares = 0;

  param_seq_detector #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .z(z), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  bit       mq[$];          // accepted bits since last clear, oldest first
  logic [LEN-1:0] mpat;
  int       mcnt;
  bit       mvalid = 1'b0;

  function automatic bit model_z();
    logic [LEN-1:0] w;
    if (!x_valid || cfg_load || mq.size() != LEN - 1) return 1'b0;
    w = '0;
    foreach (mq[i]) w = {w[LEN-2:0], mq[i]};
    w = {w[LEN-2:0], x};
    return (w == mpat);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete(); mpat = 4'b1010; mcnt = 0; mvalid = 1'b1;
    end else if (cfg_load) begin
      mq.delete(); mpat = cfg_pattern; mcnt = 0;
    end else if (x_valid) begin
      bit m;
      m = model_z();
      if (m && CNT_EN) mcnt = (mcnt < 3) ? mcnt + 1 : 3;
      if (m && !overlap) mq.delete();
      else begin
        mq.push_back(x);
        if (mq.size() > LEN - 1) void'(mq.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      if (rst_n) check("z_model", 32'(z), 32'(model_z()));
      check("cnt_model", 32'(match_cnt), 32'(mcnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic v, input logic b, input logic ov,
                      input logic ld, input logic [LEN-1:0] p, output logic zo);
    rst_n = r; x_valid = v; x = b; overlap = ov; cfg_load = ld; cfg_pattern = p;
    @(negedge clk);
    zo = z;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    logic zd;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, zd);
  endtask

  // Drives n valid bits, MSB of bits first; zs collects z, first bit at MSB.
  task automatic run_bits(input logic [15:0] bits, input int n, input logic ov,
                          output logic [15:0] zs);
    logic zb;
    logic [15:0] b;
    b = bits;
    zs = '0;
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, 1'b1, b[i], ov, 1'b0, '0, zb);
      zs = {zs[14:0], zb};
    end
  endtask

  initial begin
    logic [15:0] zs;
    logic [15:0] lit;
    logic zb;

    do_reset();
    check("reset_cnt", 32'(match_cnt), 32'd0);

    // Overlapping, default pattern 1010
    run_bits(16'b101010, 6, 1'b1, zs);
    check("ovl_z", 32'(zs), 32'b000101);
    check("ovl_cnt", 32'(match_cnt), CNT_EN ? 32'd2 : 32'd0);

    // Non-overlapping
    do_reset();
    run_bits(16'b101010, 6, 1'b0, zs);
    check("novl_z", 32'(zs), 32'b000100);
    check("novl_cnt", 32'(match_cnt), CNT_EN ? 32'd1 : 32'd0);

    // x_valid gaps between bit 2 and bit 3
    do_reset();
    run_bits(16'b10, 2, 1'b1, zs);
    lit = zs;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, i[0], 1'b1, 1'b0, '0, zb);
      lit = {lit[14:0], zb};
    end
    run_bits(16'b10, 2, 1'b1, zs);
    lit = {lit[13:0], zs[1:0]};
    check("gap_z", 32'(lit[6:0]), 32'b0000001);
    check("gap_cnt", 32'(match_cnt), CNT_EN ? 32'd1 : 32'd0);

    // cfg_load 1111 with a discarded 1, then seven 1s; counter saturates at 3
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, zb);
    check("load_z", 32'(zb), 32'd0);
    run_bits(16'b1111111, 7, 1'b1, zs);
    check("self_ovl_z", 32'(zs), 32'b0001111);
    check("sat_cnt", 32'(match_cnt), CNT_EN ? 32'd3 : 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, zb);
    check("reload_z", 32'(zb), 32'd0);
    check("reload_cnt", 32'(match_cnt), 32'd0);

    // Mid-stream reset discards history, then default pattern is back
    run_bits(16'b101, 3, 1'b1, zs);
    check("pre_rst_z", 32'(zs), 32'b000);
    do_reset();
    run_bits(16'b01010, 5, 1'b1, zs);
    check("post_rst_z", 32'(zs), 32'b00001);
    check("post_rst_cnt", 32'(match_cnt), CNT_EN ? 32'd1 : 32'd0);

    // Non-overlap on self-overlapping pattern: every 4th 1 matches
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, zb);
    run_bits(16'hFF, 8, 1'b0, zs);
    check("novl_1111_z", 32'(zs), 32'b00010001);

    // Overlap switched mid-stream (takes effect on next accepted bit)
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, zb);
    run_bits(16'b0110, 4, 1'b0, zs);
    check("sw_a_z", 32'(zs), 32'b0001);
    run_bits(16'b110110, 6, 1'b1, zs);
    check("sw_b_z", 32'(zs), 32'b000001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
